// File: rtl/mux4_rr_arbiter_if.sv
// Bundle of the four request/data channels and the shared output channel
// of the round-robin arbiter. The arbiter uses the slave view; the
// producers/consumer side (or a testbench) uses the master view.
interface mux4_rr_arbiter_if #(
  parameter int WIDTH = 32
);
  logic [3:0]       req;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_c;
  logic [WIDTH-1:0] in_d;
  logic             out_ready;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [3:0]       ack;

  modport master (
    output req, in_a, in_b, in_c, in_d, out_ready,
    input  gnt, sel, out_valid, out_data, ack
  );

  modport slave (
    input  req, in_a, in_b, in_c, in_d, out_ready,
    output gnt, sel, out_valid, out_data, ack
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one output channel between four requesters.
// A grant lasts until the owner drops its request or has delivered
// MAX_BURST beats; the next owner is chosen starting just after the
// previous one, so handover happens without an idle cycle.
module mux4_rr_arbiter #(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input logic              clk,
  input logic              reset,
  mux4_rr_arbiter_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_n;
  logic [1:0]       sel, sel_n;
  logic [1:0]       ptr, ptr_n;
  logic [3:0]       gnt, gnt_n;
  logic [7:0]       beat_cnt, beat_cnt_n;
  logic [1:0]       next_sel;
  logic             valid;
  logic             beat;
  logic             rel;
  logic [WIDTH-1:0] data_mux;

  // First requester found scanning from index p upwards, wrapping 3->0.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic       found;
    pick  = p;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = p + 2'(i);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  // State registers; reset discards any burst in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sel      <= 2'd0;
      gnt      <= 4'd0;
      ptr      <= 2'd0;
      beat_cnt <= 8'd0;
    end else begin
      state    <= state_n;
      sel      <= sel_n;
      gnt      <= gnt_n;
      ptr      <= ptr_n;
      beat_cnt <= beat_cnt_n;
    end
  end

  // Handshake: a beat moves whenever the owner still requests and the consumer is ready.
  always_comb begin
    valid = (state == GRANT) && bus.req[sel];
    beat  = valid && bus.out_ready;
  end

  // Data path: the selected input is always routed, valid tells whether it matters.
  always_comb begin
    data_mux = bus.in_a;
    case (sel)
      2'd0: data_mux = bus.in_a;
      2'd1: data_mux = bus.in_b;
      2'd2: data_mux = bus.in_c;
      2'd3: data_mux = bus.in_d;
    endcase
  end

  // Next-state logic: grant from idle, count beats, rotate on release.
  always_comb begin
    state_n    = state;
    sel_n      = sel;
    gnt_n      = gnt;
    ptr_n      = ptr;
    beat_cnt_n = beat_cnt;
    rel        = 1'b0;
    next_sel   = 2'd0;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          next_sel   = pick(bus.req, ptr);
          sel_n      = next_sel;
          gnt_n      = 4'b0001 << next_sel;
          beat_cnt_n = 8'd0;
          state_n    = GRANT;
        end
      end
      GRANT: begin
        rel = !bus.req[sel] || (beat && (beat_cnt == 8'(MAX_BURST - 1)));
        if (rel) begin
          ptr_n      = sel + 2'd1;
          beat_cnt_n = 8'd0;
          if (|bus.req) begin
            next_sel = pick(bus.req, sel + 2'd1);
            sel_n    = next_sel;
            gnt_n    = 4'b0001 << next_sel;
          end else begin
            gnt_n   = 4'd0;
            state_n = IDLE;
          end
        end else if (beat) begin
          beat_cnt_n = beat_cnt + 8'd1;
        end
      end
    endcase
  end

  assign bus.gnt       = gnt;
  assign bus.sel       = sel;
  assign bus.out_valid = valid;
  assign bus.out_data  = data_mux;
  assign bus.ack       = beat ? (4'b0001 << sel) : 4'b0000;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Testbench for the four-way round-robin arbiter: directed scenarios with
// known constants, followed by a long randomized run against a reference
// model of owner, rotation pointer and burst length.
module tb_mux4_rr_arbiter;

  localparam int WIDTH     = 32;
  localparam int MAX_BURST = 4;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mux4_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

  mux4_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req = 4'd0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_data();
    bus.in_a = 32'd32767;
    bus.in_b = 32'd16383;
    bus.in_c = 32'd65535;
    bus.in_d = 32'd2481;
  endtask

  // First set bit of r scanning from start upward, wrapping; -1 when r is empty.
  function automatic int first_from(input logic [3:0] r, input int start);
    first_from = -1;
    for (int k = 0; k < 4; k++)
      if (first_from < 0 && r[(start + k) % 4]) first_from = (start + k) % 4;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bus.req = 4'b1111;
    bus.out_ready = 1'b1;
    set_data();
    tick();
    tick();
    checks++;
    if (bus.gnt !== 4'b0000 || bus.sel !== 2'b00 || bus.out_valid !== 1'b0 || bus.ack !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset: gnt=%b sel=%b valid=%b ack=%b, expected 0000 00 0 0000",
               bus.gnt, bus.sel, bus.out_valid, bus.ack);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_b();
    do_reset();
    set_data();
    bus.req = 4'b0010;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.gnt !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL single_b_latency: gnt=%b, expected 0000", bus.gnt);
    end
    tick();
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (bus.gnt !== 4'b0010 || bus.sel !== 2'b01 || bus.ack !== 4'b0010 || bus.out_data !== 32'd16383) begin
        errors++;
        $display("[TB] FAIL single_b cycle %0d: gnt=%b sel=%b ack=%b data=%0d, expected 0010 01 0010 16383",
                 i, bus.gnt, bus.sel, bus.ack, bus.out_data);
      end
      tick();
    end
  endtask

  task automatic test_rotation();
    logic [31:0] vals [4];
    int idx;
    vals[0] = 32'd32767; vals[1] = 32'd16383; vals[2] = 32'd65535; vals[3] = 32'd2481;
    do_reset();
    set_data();
    bus.req = 4'b1111;
    bus.out_ready = 1'b1;
    tick();
    for (int k = 0; k < 17; k++) begin
      idx = (k / MAX_BURST) % 4;
      checks++;
      if (bus.sel !== 2'(idx) || bus.gnt !== 4'(1 << idx) || bus.ack !== 4'(1 << idx) || bus.out_data !== vals[idx]) begin
        errors++;
        $display("[TB] FAIL rotation beat %0d: sel=%b gnt=%b ack=%b data=%0d, expected sel=%0d data=%0d",
                 k, bus.sel, bus.gnt, bus.ack, bus.out_data, idx, vals[idx]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_ack;
    do_reset();
    set_data();
    bus.req = 4'b0011;
    bus.out_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.ack !== 4'b0000 || bus.gnt !== 4'b0001 || bus.out_valid !== 1'b1 || bus.out_data !== 32'd32767) begin
        errors++;
        $display("[TB] FAIL backpressure stall %0d: ack=%b gnt=%b valid=%b data=%0d, expected 0000 0001 1 32767",
                 i, bus.ack, bus.gnt, bus.out_valid, bus.out_data);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      exp_ack = (i < MAX_BURST) ? 4'b0001 : 4'b0010;
      checks++;
      if (bus.ack !== exp_ack) begin
        errors++;
        $display("[TB] FAIL backpressure resume %0d: ack=%b, expected %b", i, bus.ack, exp_ack);
      end
      tick();
    end
  endtask

  task automatic test_drop();
    do_reset();
    set_data();
    bus.req = 4'b0101;
    bus.out_ready = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bus.ack !== 4'b0001 || bus.out_data !== 32'd32767) begin
        errors++;
        $display("[TB] FAIL drop beat %0d: ack=%b data=%0d, expected 0001 32767", i, bus.ack, bus.out_data);
      end
      tick();
    end
    bus.req = 4'b0100;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.ack !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL drop_cycle: valid=%b ack=%b, expected 0 0000", bus.out_valid, bus.ack);
    end
    tick();
    checks++;
    if (bus.gnt !== 4'b0100 || bus.sel !== 2'b10 || bus.out_data !== 32'd65535) begin
      errors++;
      $display("[TB] FAIL drop_handover: gnt=%b sel=%b data=%0d, expected 0100 10 65535",
               bus.gnt, bus.sel, bus.out_data);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    set_data();
    bus.req = 4'b0100;
    bus.out_ready = 1'b1;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (bus.gnt !== 4'b0000 || bus.out_valid !== 1'b0 || bus.ack !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_mid: gnt=%b valid=%b ack=%b, expected 0000 0 0000",
               bus.gnt, bus.out_valid, bus.ack);
    end
    reset = 1'b0;
    bus.req = 4'b1111;
    tick();
    checks++;
    if (bus.gnt !== 4'b0001 || bus.sel !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_mid_regrant: gnt=%b sel=%b, expected 0001 00", bus.gnt, bus.sel);
    end
  endtask

  task automatic test_random();
    int          owner;
    int          ptr;
    int          beats;
    int          b;
    logic [3:0]  r;
    logic        rdy;
    logic [31:0] vals [4];
    logic [3:0]  exp_gnt;
    logic        exp_valid;
    logic [3:0]  exp_ack;
    do_reset();
    owner = -1;
    ptr   = 0;
    beats = 0;
    r     = 4'd0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 4) == 0) begin
        b = $urandom_range(0, 3);
        r[b] = ~r[b];
      end
      rdy = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 4; k++) vals[k] = $urandom;
      bus.req = r;
      bus.out_ready = rdy;
      bus.in_a = vals[0];
      bus.in_b = vals[1];
      bus.in_c = vals[2];
      bus.in_d = vals[3];
      #1;
      exp_gnt   = (owner < 0) ? 4'd0 : 4'(1 << owner);
      exp_valid = (owner >= 0) && r[owner];
      exp_ack   = (exp_valid && rdy) ? 4'(1 << owner) : 4'd0;
      checks++;
      if (bus.gnt !== exp_gnt || bus.out_valid !== exp_valid || bus.ack !== exp_ack) begin
        errors++;
        $display("[TB] FAIL random cycle %0d: gnt=%b valid=%b ack=%b, expected gnt=%b valid=%b ack=%b",
                 cyc, bus.gnt, bus.out_valid, bus.ack, exp_gnt, exp_valid, exp_ack);
      end
      if (owner >= 0) begin
        checks++;
        if (bus.sel !== 2'(owner) || (exp_valid && bus.out_data !== vals[owner])) begin
          errors++;
          $display("[TB] FAIL random_route cycle %0d: sel=%b data=%h, expected sel=%0d data=%h",
                   cyc, bus.sel, bus.out_data, owner, vals[owner]);
        end
      end
      tick();
      if (owner < 0) begin
        if (r != 4'd0) begin
          owner = first_from(r, ptr);
          beats = 0;
        end
      end else if (!r[owner] || (rdy && beats + 1 == MAX_BURST)) begin
        ptr   = (owner + 1) % 4;
        beats = 0;
        owner = first_from(r, ptr);
      end else if (rdy) begin
        beats++;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.req = 4'd0;
    bus.out_ready = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_c = '0;
    bus.in_d = '0;
    test_reset();
    test_single_b();
    test_rotation();
    test_backpressure();
    test_drop();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
